// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared types and defaults for the SRAM FIFO sequencer.
// Holds the FSM state enum, default widths and the read-latency ceiling.
package sram_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RWAIT
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int MAX_READ_LAT = 3;

endpackage

// File: rtl/sram_fifo_ptrs.sv
// sram_fifo_ptrs: circular-buffer pointers and occupancy for the FIFO.
// Ports: clk, rst (sync, active-low), inc_wr, inc_rd -> wr_ptr, rd_ptr,
// count, full, empty.
module sram_fifo_ptrs
  import sram_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_wr,
  input  logic              inc_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  // Pointers are exactly ADDR_W wide, so the 7->0 wrap is free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (inc_wr) wr_ptr <= wr_ptr + 1'b1;
      if (inc_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({inc_wr, inc_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: push/pop FIFO sequencer driving an SRAM controller.
// Ports: push_valid/push_data/push_ready, pop_req/pop_ready/pop_valid/
// pop_data, full/empty/count/err, sram_write/sram_read/sram_addr/
// sram_data_in/sram_data_out. clk, rst (sync, active-low).
// Option: SRAM_FIFO_ERR_EN enables the sticky misuse flag on err.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              sram_write,
  output logic              sram_read,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  localparam int WCNT_W = $clog2(MAX_READ_LAT);
  localparam logic [WCNT_W-1:0] WLOAD =
    WCNT_W'(READ_LAT - 1);

  state_t            state;
  logic              last_was_pop;
  logic [WCNT_W-1:0] wcnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              idle;
  logic              push_ok;
  logic              pop_ok;
  logic              push_go;
  logic              pop_go;
  logic              inc_wr;
  logic              inc_rd;

  // Ready is held low while reset is asserted.
  assign idle    = rst && (state == ST_IDLE);
  assign push_ok = push_valid && !full;
  assign pop_ok  = pop_req && !empty;

  // On a clash the side that did not go last wins.
  assign push_ready = idle && !full
                      && !(pop_ok && !last_was_pop);
  assign pop_ready  = idle && !empty
                      && !(push_ok && last_was_pop);

  assign push_go = push_valid && push_ready;
  assign pop_go  = pop_req && pop_ready;

  assign inc_wr = (state == ST_WRITE);
  assign inc_rd = (state == ST_RWAIT) && (wcnt == '0);

  sram_fifo_ptrs #(
    .ADDR_W (ADDR_W)
  ) u_ptrs (
    .clk    (clk),
    .rst    (rst),
    .inc_wr (inc_wr),
    .inc_rd (inc_rd),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_was_pop <= 1'b0;
      wcnt         <= '0;
      sram_write   <= 1'b0;
      sram_read    <= 1'b0;
      sram_addr    <= '0;
      sram_data_in <= '0;
      pop_valid    <= 1'b0;
      pop_data     <= '0;
    end else begin
      sram_write <= 1'b0;
      sram_read  <= 1'b0;
      pop_valid  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (push_go) begin
            state        <= ST_WRITE;
            sram_write   <= 1'b1;
            sram_addr    <= wr_ptr;
            sram_data_in <= push_data;
            last_was_pop <= 1'b0;
          end else if (pop_go) begin
            state        <= ST_READ;
            sram_read    <= 1'b1;
            sram_addr    <= rd_ptr;
            last_was_pop <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        ST_READ: begin
          state <= ST_RWAIT;
          wcnt  <= WLOAD;
        end
        ST_RWAIT: begin
          if (wcnt == '0) begin
            state     <= ST_IDLE;
            pop_data  <= sram_data_out;
            pop_valid <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == ST_IDLE
                 && ((push_valid && full)
                     || (pop_req && empty))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: randomized bench for sram_fifo_ctrl against a
// queue-based FIFO model with an SRAM behavioural model attached.
module tb_sram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int RL    = 1;

  logic          clk;
  logic          rst;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_req;
  logic          pop_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          err;
  logic          sram_write;
  logic          sram_read;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out;

  sram_fifo_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .READ_LAT (RL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .pop_req       (pop_req),
    .pop_ready     (pop_ready),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .err           (err),
    .sram_write    (sram_write),
    .sram_read     (sram_read),
    .sram_addr     (sram_addr),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with a one-cycle registered read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_write) mem[sram_addr] <= sram_data_in;
    if (sram_read) sram_data_out <= mem[sram_addr];
  end

  int n_chk;
  int n_pass;
  bit done;

  logic [DW-1:0] q[$];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  bit            lwp;
  bit            err_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!done)
        chk("strobe_excl", 32'(sram_write & sram_read), 32'd0);
    end
  end

  task automatic model_reset();
    q.delete();
    wptr  = '0;
    rptr  = '0;
    lwp   = 1'b0;
    err_m = 1'b0;
  endtask

  // One request cycle in IDLE, then follow whatever was granted.
  task automatic run_op(input bit pv, input bit pr,
                        input logic [DW-1:0] d);
    bit push_ok, pop_ok, exp_prdy, exp_qrdy;
    bit go_push, go_pop;
    logic [DW-1:0] exp_d;
    int sz;
    sz       = q.size();
    push_ok  = pv && sz < DEPTH;
    pop_ok   = pr && sz > 0;
    exp_prdy = sz < DEPTH && !(pop_ok && !lwp);
    exp_qrdy = sz > 0 && !(push_ok && lwp);
    go_push  = push_ok && exp_prdy;
    go_pop   = pop_ok && exp_qrdy;
    push_valid = pv;
    push_data  = d;
    pop_req    = pr;
    #1;
    chk("push_ready", 32'(push_ready), 32'(exp_prdy));
    chk("pop_ready", 32'(pop_ready), 32'(exp_qrdy));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("count", 32'(count), 32'(sz));
`ifdef SRAM_FIFO_ERR_EN
    if ((pv && sz == DEPTH) || (pr && sz == 0)) err_m = 1'b1;
`endif
    @(negedge clk);
    push_valid = 1'b0;
    pop_req    = 1'b0;
    #1;
    chk("err", 32'(err), 32'(err_m));
    if (go_push) begin
      chk("wr_strobe", 32'(sram_write), 32'd1);
      chk("wr_addr", 32'(sram_addr), 32'(wptr));
      chk("wr_data", 32'(sram_data_in), 32'(d));
      q.push_back(d);
      wptr = wptr + 1'b1;
      lwp  = 1'b0;
      @(negedge clk);
      #1;
      chk("wr_once", 32'(sram_write), 32'd0);
      chk("cnt_after_wr", 32'(count), 32'(q.size()));
    end else if (go_pop) begin
      chk("rd_strobe", 32'(sram_read), 32'd1);
      chk("rd_addr", 32'(sram_addr), 32'(rptr));
      exp_d = q.pop_front();
      rptr  = rptr + 1'b1;
      lwp   = 1'b1;
      repeat (RL) begin
        @(negedge clk);
        #1;
        chk("rd_once", 32'(sram_read), 32'd0);
        chk("pv_early", 32'(pop_valid), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("pop_valid", 32'(pop_valid), 32'd1);
      chk("pop_data", 32'(pop_data), 32'(exp_d));
      chk("cnt_after_rd", 32'(count), 32'(q.size()));
    end else begin
      chk("no_wr", 32'(sram_write), 32'd0);
      chk("no_rd", 32'(sram_read), 32'd0);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    done       = 1'b0;
    rst        = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_req    = 1'b0;
    model_reset();

    repeat (5) begin
      @(negedge clk);
      #1;
      chk("rst_wr", 32'(sram_write), 32'd0);
      chk("rst_rd", 32'(sram_read), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_push_rdy", 32'(push_ready), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_pop_data", 32'(pop_data), 32'd0);
    end
    rst = 1'b1;

    // Push 1..4 then drain in order.
    for (int i = 1; i <= 4; i++) run_op(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 4; i++) run_op(1'b0, 1'b1, '0);

    // Fill, push at full, pop 2, push 2, drain.
    for (int i = 0; i < DEPTH; i++) run_op(1'b1, 1'b0, DW'($urandom));
    run_op(1'b1, 1'b0, 8'hee);
    run_op(1'b1, 1'b0, 8'hef);
    run_op(1'b0, 1'b1, '0);
    run_op(1'b0, 1'b1, '0);
    run_op(1'b1, 1'b0, 8'h5a);
    run_op(1'b1, 1'b0, 8'ha5);
    while (q.size() > 0) run_op(1'b0, 1'b1, '0);

    // Pop while empty.
    run_op(1'b0, 1'b1, '0);

    // Simultaneous requests at count 2.
    run_op(1'b1, 1'b0, 8'h11);
    run_op(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 3; i++) run_op(1'b1, 1'b1, DW'(8'h30 + i));

    // Random mix.
    for (int i = 0; i < 150; i++)
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             DW'($urandom));

    // Reset during the READ cycle.
    while (q.size() < 2) run_op(1'b1, 1'b0, DW'($urandom));
    pop_req = 1'b1;
    #1;
    chk("mr_pop_rdy", 32'(pop_ready), 32'(q.size() > 0));
    @(negedge clk);
    pop_req = 1'b0;
    #1;
    chk("mr_rd", 32'(sram_read), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_rd_drop", 32'(sram_read), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_err", 32'(err), 32'd0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mr_no_pv", 32'(pop_valid), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("mr_idle", 32'(push_ready), 32'd1);
    run_op(1'b1, 1'b0, 8'h77);
    run_op(1'b0, 1'b1, '0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
